// File: rtl/vram_arbiter.sv
// Arbitrates the single-port VRAM between the display reader (absolute priority) and a CPU port with posted writes.
// Latency: display read data 1 clk after request; CPU read accept T, issue T+1 at the earliest, rvalid T+2.
// Backpressure: cpu_ready drops while a read is outstanding, or for writes while the post FIFO is full.
module vram_arbiter #(
    parameter int AW     = 11,
    parameter int DW     = 8,
    parameter int WDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      disp_req,
    input  logic [AW-1:0]             disp_addr,
    output logic [DW-1:0]             disp_data,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [AW-1:0]             cpu_addr,
    input  logic [DW-1:0]             cpu_wdata,
    output logic                      cpu_ready,
    output logic [DW-1:0]             cpu_rdata,
    output logic                      cpu_rvalid,
    output logic [AW-1:0]             vram_addr,
    output logic                      vram_we,
    output logic [DW-1:0]             vram_wdata,
    input  logic [DW-1:0]             vram_rdata,
    output logic [$clog2(WDEPTH):0]   wfifo_count,
    output logic                      busy
);
    localparam int PW = $clog2(WDEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] fifo_addr [WDEPTH];
    logic [DW-1:0] fifo_data [WDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          rd_pend;
    logic          rd_issued;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rdata_hold;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic rd_acc;
    logic rd_go;

    // Handshake and slot selection; the display always takes the slot, a read waits behind every posted write.
    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == CW'(WDEPTH));
        cpu_ready  = ~rd_pend & ~rd_issued & (cpu_we ? ~fifo_full : 1'b1);
        push       = cpu_req & cpu_ready & cpu_we;
        rd_acc     = cpu_req & cpu_ready & ~cpu_we;
        pop        = ~disp_req & ~fifo_empty;
        rd_go      = ~disp_req & fifo_empty & rd_pend;
    end

    // VRAM port mux: idle cycles park on the display address so the display path sees no change.
    always_comb begin
        vram_addr  = disp_addr;
        vram_we    = 1'b0;
        vram_wdata = fifo_data[head];
        if (pop) begin
            vram_addr = fifo_addr[head];
            vram_we   = 1'b1;
        end else if (rd_go) begin
            vram_addr = rd_addr;
        end
    end

    // Post FIFO storage; the pointers and occupancy live in the control block below.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[tail] <= cpu_addr;
            fifo_data[tail] <= cpu_wdata;
        end
    end

    // Pointer/count bookkeeping and the blocking-read tracker; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            rd_pend    <= 1'b0;
            rd_issued  <= 1'b0;
            rd_addr    <= '0;
            rdata_hold <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (rd_acc) begin
                rd_pend <= 1'b1;
                rd_addr <= cpu_addr;
            end else if (rd_go) begin
                rd_pend <= 1'b0;
            end
            rd_issued <= rd_go;
            if (rd_issued) rdata_hold <= vram_rdata;
        end
    end

    // Read data is live in the completion cycle and held from the register afterwards.
    always_comb begin
        disp_data   = vram_rdata;
        cpu_rvalid  = rd_issued;
        cpu_rdata   = rd_issued ? vram_rdata : rdata_hold;
        wfifo_count = count;
        busy        = (count != '0) | rd_pend | rd_issued;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus random traffic against a queue-based reference model.
// The bench also models the synchronous VRAM macro (read-first, 1 clk read latency).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_vram_arbiter;
    localparam int AW = 11;
    localparam int DW = 8;
    localparam int WDEPTH = 4;

    logic          clk;
    logic          reset;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    logic [AW-1:0] vram_addr;
    logic          vram_we;
    logic [DW-1:0] vram_wdata;
    logic [DW-1:0] vram_rdata;
    logic [2:0]    wfifo_count;
    logic          busy;

    vram_arbiter #(.AW(AW), .DW(DW), .WDEPTH(WDEPTH)) dut (
        .clk(clk), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
        .wfifo_count(wfifo_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM macro model
    logic [DW-1:0] mem [2048];
    always @(posedge clk) begin
        if (vram_we) mem[vram_addr] <= vram_wdata;
        vram_rdata <= mem[vram_addr];
    end

    // Reference model state: what the VRAM should contain, pending posted writes, read progress
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    wr_t           wq[$];
    logic [DW-1:0] shadow [2048];
    int            rd_st;          // 0 none, 1 accepted not yet issued, 2 completing this cycle
    logic [AW-1:0] rd_a;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] last_rd;
    logic          have_rd;
    logic          prev_disp;
    logic [DW-1:0] prev_disp_val;
    int            cyc;

    int checks;
    int failures;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock: drive inputs, compare every output with the model, then advance the model.
    task automatic step(input logic d, input logic [AW-1:0] da, input logic rq, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic rst,
                        output logic acc, output logic rv);
        logic          e_ready;
        int            slot;           // 0 display/idle, 1 write, 2 read
        logic [AW-1:0] e_addr;
        disp_req = d; disp_addr = da; cpu_req = rq; cpu_we = we;
        cpu_addr = a; cpu_wdata = wd; reset = rst;
        #1;
        e_ready = (rd_st == 0) && (we ? (wq.size() < WDEPTH) : 1'b1);
        slot = 0;
        e_addr = da;
        if (!d && wq.size() != 0) begin
            slot = 1;
            e_addr = wq[0].a;
        end else if (!d && rd_st == 1) begin
            slot = 2;
            e_addr = rd_a;
        end
        chk("cpu_ready", 32'(cpu_ready), 32'(e_ready));
        chk("vram_we", 32'(vram_we), 32'(slot == 1));
        chk("vram_addr", 32'(vram_addr), 32'(e_addr));
        if (slot == 1) chk("vram_wdata", 32'(vram_wdata), 32'(wq[0].d));
        chk("wfifo_count", 32'(wfifo_count), 32'(wq.size()));
        chk("busy", 32'(busy), 32'(wq.size() != 0 || rd_st != 0));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(rd_st == 2));
        if (rd_st == 2) chk("cpu_rdata", 32'(cpu_rdata), 32'(rd_data));
        else if (have_rd) chk("cpu_rdata_hold", 32'(cpu_rdata), 32'(last_rd));
        if (prev_disp) chk("disp_data", 32'(disp_data), 32'(prev_disp_val));
        rv  = cpu_rvalid;
        acc = rq & e_ready & ~rst;
        @(posedge clk);
        cyc++;
        prev_disp = d;
        if (d) prev_disp_val = shadow[da];
        if (rd_st == 2) begin
            last_rd = rd_data;
            have_rd = 1'b1;
            rd_st = 0;
        end
        if (slot == 1) begin
            shadow[wq[0].a] = wq[0].d;
            void'(wq.pop_front());
        end
        if (slot == 2) begin
            rd_data = shadow[rd_a];
            rd_st = 2;
        end
        if (acc && we) wq.push_back('{a, wd});
        if (acc && !we) begin
            rd_st = 1;
            rd_a = a;
        end
        if (rst) begin
            wq.delete();
            rd_st = 0;
            have_rd = 1'b0;
        end
        @(negedge clk);
    endtask

    // Hold a CPU request until the model says it is accepted (bounded).
    task automatic xfer(input logic d, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, output int tries);
        logic acc, rv;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            step(d, 11'h3C0, 1'b1, we, a, wd, 1'b0, acc, rv);
            tries++;
        end
        chk("xfer_accepted", 32'(acc), 32'd1);
    endtask

    task automatic idle(input logic d, input int n, output int rv_cnt);
        logic acc, rv;
        rv_cnt = 0;
        for (int i = 0; i < n; i++) begin
            step(d, 11'(200 + i), 1'b0, 1'b0, 11'h0, 8'h0, 1'b0, acc, rv);
            if (rv) rv_cnt++;
        end
    endtask

    logic [AW-1:0] pool [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int tries, n, rvc;
        logic acc, rv;
        logic          r_d, r_req, r_we, r_rst;
        logic [AW-1:0] r_a;
        logic [DW-1:0] r_wd;
        int            hog;

        checks = 0; failures = 0; cyc = 0;
        rd_st = 0; have_rd = 1'b0; prev_disp = 1'b0;
        rd_a = '0; rd_data = '0; last_rd = '0; prev_disp_val = '0;
        pool[0] = 11'h100; pool[1] = 11'h101; pool[2] = 11'h102;
        pool[3] = 11'h103; pool[4] = 11'h7FF; pool[5] = 11'h000;
        for (int i = 0; i < 2048; i++) begin
            mem[i]    <= 8'(i * 37 + 5);
            shadow[i]  = 8'(i * 37 + 5);
        end
        disp_req = 1'b0; disp_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, idle
        idle(1'b0, 2, rvc);

        // Three posted writes drain back-to-back with the display idle
        xfer(1'b0, 1'b1, 11'h040, 8'h41, tries);
        xfer(1'b0, 1'b1, 11'h041, 8'h42, tries);
        xfer(1'b0, 1'b1, 11'h042, 8'h43, tries);
        idle(1'b0, 3, rvc);

        // Display hogs: four writes fill the FIFO, a fifth is refused, then all drain in order
        for (int i = 0; i < 4; i++) xfer(1'b1, 1'b1, 11'(16'h0300 + i), 8'(8'hB0 + i), tries);
        step(1'b1, 11'h3C0, 1'b1, 1'b1, 11'h310, 8'hEE, 1'b0, acc, rv);
        chk("full_refused", 32'(acc), 32'd0);
        idle(1'b0, 5, rvc);

        // Full FIFO, pop and CPU write in the same cycle: refused first, accepted next
        for (int i = 0; i < 4; i++) xfer(1'b1, 1'b1, 11'(16'h0320 + i), 8'(8'hC0 + i), tries);
        xfer(1'b0, 1'b1, 11'h324, 8'hC4, tries);
        chk("full_pop_tries", 32'(tries), 32'd2);
        idle(1'b0, 6, rvc);

        // Write then read same address while the display holds two cycles
        xfer(1'b1, 1'b1, 11'h100, 8'hAA, tries);
        xfer(1'b1, 1'b0, 11'h100, 8'h00, tries);
        idle(1'b1, 2, rvc);
        idle(1'b0, 6, rvc);
        chk("raw_rvalid_count", 32'(rvc), 32'd1);
        chk("raw_rdata", 32'(cpu_rdata), 32'hAA);

        // Idle read latency at the top address
        step(1'b0, 11'h3C0, 1'b1, 1'b0, 11'h7FF, 8'h00, 1'b0, acc, rv);
        chk("lat_accept", 32'(acc), 32'd1);
        n = 0;
        rv = 1'b0;
        while (!rv && n < 8) begin
            step(1'b0, 11'h3C0, 1'b0, 1'b0, 11'h0, 8'h0, 1'b0, acc, rv);
            n++;
        end
        chk("read_latency", 32'(n), 32'd2);

        // Reset with three writes posted and a read pending
        for (int i = 0; i < 3; i++) xfer(1'b1, 1'b1, 11'(16'h0500 + i), 8'(8'hD0 + i), tries);
        xfer(1'b1, 1'b0, 11'h500, 8'h00, tries);
        step(1'b1, 11'h3C0, 1'b0, 1'b0, 11'h0, 8'h0, 1'b1, acc, rv);
        idle(1'b0, 5, rvc);
        chk("rst_no_rvalid", 32'(rvc), 32'd0);

        // Random traffic; the CPU holds a request until it is taken
        hog = 0;
        r_req = 1'b0; r_we = 1'b0; r_a = '0; r_wd = '0;
        for (int k = 0; k < 4000; k++) begin
            if (hog > 0) begin
                r_d = 1'b1;
                hog--;
            end else if ($urandom_range(0, 199) == 0) begin
                r_d = 1'b1;
                hog = int'($urandom_range(3, 20));
            end else begin
                r_d = ($urandom_range(0, 7) == 0);
            end
            if (!r_req && $urandom_range(0, 1) == 1) begin
                r_req = 1'b1;
                r_we  = ($urandom_range(0, 9) < 6);
                r_a   = pool[$urandom_range(0, 5)];
                r_wd  = 8'($urandom_range(0, 255));
            end
            r_rst = ($urandom_range(0, 599) == 0);
            step(r_d, 11'($urandom_range(0, 2047)), r_req, r_we, r_a, r_wd, r_rst, acc, rv);
            if (acc || r_rst) r_req = 1'b0;
        end
        idle(1'b0, 8, rvc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
